counter_sequencer: RTL and testbench

- Controller that sequences the N-bit LED counter datapath.
- Accepts start, stop and single-step commands and latches a modulus limit, a direction and a lap count.
- Drives the counter value directly; flags terminal-count wraps and auto-stops after a programmed number of laps.
- Sits between panel push-buttons/switches and the LED outputs, replacing the free-running JK cascade.

---
 rtl/counter_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_counter_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// counter_sequencer: run/stop/step controller for the N-bit LED counter.
// Latches a modulus limit, count direction and lap target at start, then
// advances the count every clock while running, flagging each wrap and
// auto-stopping once the programmed number of laps has completed.
//
// Optional feature macro: COUNTER_SEQ_PAUSE_EN (adds cmd_pause and PAUSE).
//
// Ports:
//   input_clock1_1  clock, rising edge
//   input_reset1_2  synchronous active-high reset
//   cmd_start       begin run (level); resumes from PAUSE when enabled
//   cmd_stop        abort run; highest command priority
//   cmd_step        single advance while idle
//   cmd_pause       (COUNTER_SEQ_PAUSE_EN only) hold a running count
//   cfg_limit       terminal value, count range 0..cfg_limit
//   cfg_down        0 = up, 1 = down
//   cfg_laps        wraps before auto-stop, 0 = run until stopped
//   output_led_q    current count
//   busy            high while running (and paused)
//   tc_pulse        one-cycle pulse on every wrap
//   done            one-cycle pulse when the lap target is reached
//   lap_count       wraps completed in the current run
module counter_sequencer #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned LAP_W = 4
) (
  input  logic             input_clock1_1,
  input  logic             input_reset1_2,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             cmd_step,
`ifdef COUNTER_SEQ_PAUSE_EN
  input  logic             cmd_pause,
`endif
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_down,
  input  logic [LAP_W-1:0] cfg_laps,
  output logic [WIDTH-1:0] output_led_q,
  output logic             busy,
  output logic             tc_pulse,
  output logic             done,
  output logic [LAP_W-1:0] lap_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2
`ifdef COUNTER_SEQ_PAUSE_EN
    , ST_PAUSE = 2'd3
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             down_q, down_d;
  logic [LAP_W-1:0] laps_q, laps_d;
  logic [LAP_W-1:0] lap_q, lap_d;
  logic             busy_q, busy_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  logic             pause_req;
  logic [WIDTH-1:0] adv_lim;
  logic             adv_down;
  logic [WIDTH-1:0] adv_cnt;
  logic             adv_wrap;
  logic [LAP_W-1:0] lap_inc;

`ifdef COUNTER_SEQ_PAUSE_EN
  assign pause_req = cmd_pause;
`else
  assign pause_req = 1'b0;
`endif

  // A step from idle uses the live config (it is latched on that same edge);
  // a run always uses the values latched at start.
  assign adv_lim  = (state_q == ST_IDLE) ? cfg_limit : lim_q;
  assign adv_down = (state_q == ST_IDLE) ? cfg_down  : down_q;

  // Wrap rule: up wraps to 0 at/after the limit, down wraps to the limit at 0
  // or when the count sits above the limit.
  always_comb begin
    adv_wrap = 1'b0;
    adv_cnt  = cnt_q;
    if (!adv_down) begin
      adv_wrap = (cnt_q >= adv_lim);
      adv_cnt  = adv_wrap ? '0 : cnt_q + WIDTH'(1);
    end else begin
      adv_wrap = (cnt_q == '0) || (cnt_q > adv_lim);
      adv_cnt  = adv_wrap ? adv_lim : cnt_q - WIDTH'(1);
    end
  end

  assign lap_inc = lap_q + LAP_W'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    down_d  = down_q;
    laps_d  = laps_q;
    lap_d   = lap_q;
    busy_d  = busy_q;
    tc_d    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (cmd_stop) begin
          state_d = ST_IDLE;
        end else if (cmd_start) begin
          lim_d   = cfg_limit;
          down_d  = cfg_down;
          laps_d  = cfg_laps;
          lap_d   = '0;
          cnt_d   = cfg_down ? cfg_limit : '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else if (cmd_step) begin
          lim_d  = cfg_limit;
          down_d = cfg_down;
          cnt_d  = adv_cnt;
          tc_d   = adv_wrap;
        end
      end
      ST_RUN: begin
        if (cmd_stop) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (pause_req) begin
`ifdef COUNTER_SEQ_PAUSE_EN
          state_d = ST_PAUSE;
`endif
        end else begin
          cnt_d = adv_cnt;
          if (adv_wrap) begin
            tc_d  = 1'b1;
            lap_d = lap_inc;
            // Lap target compares against the post-increment lap count.
            if ((laps_q != '0) && (lap_inc == laps_q)) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
`ifdef COUNTER_SEQ_PAUSE_EN
      ST_PAUSE: begin
        if (cmd_stop) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cmd_start) begin
          state_d = ST_RUN;
        end
      end
`endif
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge input_clock1_1) begin
    if (input_reset1_2) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lim_q   <= '0;
      down_q  <= 1'b0;
      laps_q  <= '0;
      lap_q   <= '0;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      down_q  <= down_d;
      laps_q  <= laps_d;
      lap_q   <= lap_d;
      busy_q  <= busy_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign output_led_q = cnt_q;
  assign busy         = busy_q;
  assign tc_pulse     = tc_q;
  assign done         = done_q;
  assign lap_count    = lap_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Testbench for counter_sequencer: directed scenarios followed by random
// commands, checked cycle by cycle against a behavioural model through a
// scoreboard queue.
module tb_counter_sequencer;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned LAP_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_start = 1'b0;
  logic             cmd_stop = 1'b0;
  logic             cmd_step = 1'b0;
  logic             cmd_pause = 1'b0;
  logic [WIDTH-1:0] cfg_limit = '0;
  logic             cfg_down = 1'b0;
  logic [LAP_W-1:0] cfg_laps = '0;
  logic [WIDTH-1:0] led;
  logic             busy, tc_pulse, done;
  logic [LAP_W-1:0] lap_count;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(WIDTH), .LAP_W(LAP_W)) dut (
    .input_clock1_1(clk),
    .input_reset1_2(rst),
    .cmd_start(cmd_start),
    .cmd_stop(cmd_stop),
    .cmd_step(cmd_step),
`ifdef COUNTER_SEQ_PAUSE_EN
    .cmd_pause(cmd_pause),
`endif
    .cfg_limit(cfg_limit),
    .cfg_down(cfg_down),
    .cfg_laps(cfg_laps),
    .output_led_q(led),
    .busy(busy),
    .tc_pulse(tc_pulse),
    .done(done),
    .lap_count(lap_count)
  );

  typedef struct packed {
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             tc;
    logic             done;
    logic [LAP_W-1:0] lap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Behavioural model: mode is a plain integer tag (0 idle, 1 run, 2 done,
  // 3 paused); everything else is held as integers.
  int m_mode = 0;
  int m_cnt = 0, m_lim = 0, m_down = 0, m_laps = 0, m_lap = 0;
  int m_busy = 0, m_tc = 0, m_done = 0;

  function automatic void advance(input int c, input int lim, input int dn,
                                  output int n, output int w);
    if (dn == 0) begin
      if (c < lim) begin n = c + 1; w = 0; end
      else         begin n = 0;     w = 1; end
    end else begin
      if (c > 0 && c <= lim) begin n = c - 1; w = 0; end
      else                   begin n = lim;   w = 1; end
    end
  endfunction

  task automatic model_step(input bit r, input bit st, input bit sp, input bit stp,
                            input bit ps, input int lim, input int dn, input int laps);
    int n, w;
    bit pause_on;
`ifdef COUNTER_SEQ_PAUSE_EN
    pause_on = ps;
`else
    pause_on = 1'b0;
`endif
    m_tc = 0;
    m_done = 0;
    if (r) begin
      m_mode = 0; m_cnt = 0; m_lim = 0; m_down = 0; m_laps = 0;
      m_lap = 0; m_busy = 0;
    end else if (m_mode == 0) begin
      if (sp) begin
        // stop in idle: nothing happens
      end else if (st) begin
        m_lim = lim; m_down = dn; m_laps = laps; m_lap = 0;
        m_cnt = (dn != 0) ? lim : 0;
        m_busy = 1; m_mode = 1;
      end else if (stp) begin
        m_lim = lim; m_down = dn;
        advance(m_cnt, m_lim, m_down, n, w);
        m_cnt = n; m_tc = w;
      end
    end else if (m_mode == 1) begin
      if (sp) begin
        m_busy = 0; m_mode = 0;
      end else if (pause_on) begin
        m_mode = 3;
      end else begin
        advance(m_cnt, m_lim, m_down, n, w);
        m_cnt = n;
        if (w != 0) begin
          m_tc = 1;
          m_lap = (m_lap + 1) % (1 << LAP_W);
          if (m_laps != 0 && m_lap == m_laps) begin
            m_done = 1; m_busy = 0; m_mode = 2;
          end
        end
      end
    end else if (m_mode == 2) begin
      m_mode = 0;
    end else begin
      if (sp) begin m_busy = 0; m_mode = 0; end
      else if (st) m_mode = 1;
    end
  endtask

  // Drive one cycle of stimulus and queue what the DUT must show after it.
  task automatic drive(input bit r, input bit st, input bit sp, input bit stp,
                       input bit ps, input int lim, input int dn, input int laps);
    exp_t e;
    @(negedge clk);
    rst = r; cmd_start = st; cmd_stop = sp; cmd_step = stp; cmd_pause = ps;
    cfg_limit = WIDTH'(lim); cfg_down = dn[0]; cfg_laps = LAP_W'(laps);
    model_step(r, st, sp, stp, ps, lim, dn, laps);
    e.cnt  = WIDTH'(m_cnt);
    e.busy = m_busy[0];
    e.tc   = m_tc[0];
    e.done = m_done[0];
    e.lap  = LAP_W'(m_lap);
    exp_q.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one registered output set per clock, compared just after the edge.
  initial begin
    exp_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        g = {led, busy, tc_pulse, done, lap_count};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: got cnt=%0d busy=%0b tc=%0b done=%0b lap=%0d, expected cnt=%0d busy=%0b tc=%0b done=%0b lap=%0d",
                   cyc, g.cnt, g.busy, g.tc, g.done, g.lap,
                   e.cnt, e.busy, e.tc, e.done, e.lap);
        end
        cyc++;
      end
    end
  end

  initial begin
    // Reset, then reset state.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 0, 5, 1, 3);
    idle_cycles(2);

    // Up run: limit 5, laps 2 -> done after 12 advances.
    drive(0, 1, 0, 0, 0, 5, 0, 2);
    idle_cycles(15);

    // Down run: limit 3, laps 1.
    drive(0, 1, 0, 0, 0, 3, 1, 1);
    idle_cycles(6);

    // Stop mid-run at count 4, limit 7 up, laps 0.
    drive(0, 1, 0, 0, 0, 7, 0, 0);
    idle_cycles(4);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    idle_cycles(3);

    // Reach count 7 then step with limit 7 up -> wrap to 0.
    drive(0, 1, 0, 0, 0, 7, 0, 0);
    idle_cycles(7);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 7, 0, 9);
    idle_cycles(1);

    // Reach count 5 then step with limit 2 -> wrap to 0; then down steps.
    drive(0, 1, 0, 0, 0, 7, 0, 0);
    idle_cycles(5);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 2, 0, 0);
    drive(0, 0, 0, 1, 0, 2, 1, 0);
    drive(0, 0, 0, 1, 0, 2, 1, 0);
    drive(0, 0, 0, 1, 0, 2, 1, 0);

    // Limit 0: wraps every advance, laps 3 -> done on third edge.
    drive(0, 1, 0, 0, 0, 0, 0, 3);
    idle_cycles(5);

    // Priority: start+stop in idle; reset during run with start held.
    drive(0, 1, 1, 1, 0, 6, 1, 1);
    drive(0, 1, 0, 0, 0, 6, 0, 0);
    drive(0, 1, 0, 0, 0, 6, 0, 0);
    drive(0, 1, 0, 0, 0, 6, 0, 0);
    drive(1, 1, 0, 0, 0, 6, 0, 0);
    idle_cycles(2);

`ifdef COUNTER_SEQ_PAUSE_EN
    // Pause at count 3 for 5 cycles, then resume.
    drive(0, 1, 0, 0, 0, 7, 0, 0);
    idle_cycles(3);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    idle_cycles(2);
    drive(0, 0, 1, 1, 1, 0, 0, 0);
    idle_cycles(1);
`endif

    // Random commands with small limits/lap targets so wraps and dones occur.
    for (int i = 0; i < 3000; i++) begin
      bit r, st, sp, stp, ps;
      r   = ($urandom_range(0, 199) == 0);
      st  = ($urandom_range(0, 9) == 0);
      sp  = ($urandom_range(0, 24) == 0);
      stp = ($urandom_range(0, 3) == 0);
      ps  = ($urandom_range(0, 11) == 0);
      drive(r, st, sp, stp, ps, int'($urandom_range(0, 7)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    end
    idle_cycles(2);

    // Every queued expectation must have been consumed.
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
